ysyx_23060171_mem_arbiter: RTL

- Two-requester arbiter sharing the single memory port between the instruction-fetch unit (IFU) and the load/store unit (LSU).
- Accepts one request at a time from either side using valid/ready handshakes, latches it, and issues it to memory.
- Keeps the grant locked until the memory response returns, then routes that response back to the owner.
- Sits between IFU/LSU and the memory/bus interface; one transaction outstanding at most.

---
 rtl/ysyx_23060171_pkg.sv | 12 +
 rtl/ysyx_23060171_arb_pick.sv | 26 ++
 rtl/ysyx_23060171_mem_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ysyx_23060171_pkg.sv
// ysyx_23060171_pkg: shared types and default widths for the IFU/LSU memory arbiter.
// Contents:
//   ARB_AW / ARB_DW / ARB_MW  default address, data and byte-mask widths
//   arb_state_e               arbiter FSM states
//   arb_owner_e               which requester owns the memory port
package ysyx_23060171_pkg;
   localparam int ARB_AW = 32;
   localparam int ARB_DW = 32;
   localparam int ARB_MW = ARB_DW / 8;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_e;
   typedef enum logic {OWN_IFU, OWN_LSU} arb_owner_e;
endpackage

// File: rtl/ysyx_23060171_arb_pick.sv
// ysyx_23060171_arb_pick: combinational two-way winner selection with an anti-starvation override.
// Ports:
//   i_ifu_v, i_lsu_v  requester valids
//   i_last_owner      owner of the previous grant
//   o_grant           some requester is valid
//   o_winner          selected requester (meaningful only when o_grant)
module ysyx_23060171_arb_pick
   import ysyx_23060171_pkg::*;
#(
   parameter bit LSU_FIRST = 1'b1
) (
   input  logic       i_ifu_v,
   input  logic       i_lsu_v,
   input  arb_owner_e i_last_owner,
   output logic       o_grant,
   output arb_owner_e o_winner
);
   // On a tie, an LSU that won last time yields to the IFU so fetch cannot starve.
   always_comb begin
      o_grant  = i_ifu_v | i_lsu_v;
      o_winner = !i_ifu_v ? OWN_LSU :
                 !i_lsu_v ? OWN_IFU :
                 (i_last_owner == OWN_LSU) ? OWN_IFU :
                 LSU_FIRST ? OWN_LSU : OWN_IFU;
   end
endmodule

// File: rtl/ysyx_23060171_mem_arbiter.sv
// ysyx_23060171_mem_arbiter: shares one memory port between IFU and LSU, one transaction outstanding.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   i_ifu_req_valid/o_ifu_req_ready   IFU fetch handshake, i_ifu_addr fetch address
//   o_ifu_resp_valid/o_ifu_rdata      IFU response pulse and data
//   i_lsu_req_valid/o_lsu_req_ready   LSU handshake, i_lsu_addr/wen/wdata/wmask payload
//   o_lsu_resp_valid/o_lsu_rdata      LSU response pulse and data
//   o_mem_req_valid/i_mem_req_ready   memory request handshake with latched o_mem_* payload
//   i_mem_resp_valid/i_mem_rdata      memory response
//   o_busy                            a transaction is in flight
//   o_proto_err                       sticky flag for a response nobody was waiting for
module ysyx_23060171_mem_arbiter
   import ysyx_23060171_pkg::*;
#(
   parameter int AW        = ARB_AW,
   parameter int DW        = ARB_DW,
   parameter bit LSU_FIRST = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_ifu_req_valid,
   output logic            o_ifu_req_ready,
   input  logic [AW-1:0]   i_ifu_addr,
   output logic            o_ifu_resp_valid,
   output logic [DW-1:0]   o_ifu_rdata,
   input  logic            i_lsu_req_valid,
   output logic            o_lsu_req_ready,
   input  logic [AW-1:0]   i_lsu_addr,
   input  logic            i_lsu_wen,
   input  logic [DW-1:0]   i_lsu_wdata,
   input  logic [DW/8-1:0] i_lsu_wmask,
   output logic            o_lsu_resp_valid,
   output logic [DW-1:0]   o_lsu_rdata,
   output logic            o_mem_req_valid,
   input  logic            i_mem_req_ready,
   output logic [AW-1:0]   o_mem_addr,
   output logic            o_mem_wen,
   output logic [DW-1:0]   o_mem_wdata,
   output logic [DW/8-1:0] o_mem_wmask,
   input  logic            i_mem_resp_valid,
   input  logic [DW-1:0]   i_mem_rdata,
   output logic            o_busy,
   output logic            o_proto_err
);
   arb_state_e      r_state, w_next;
   arb_owner_e      r_owner, r_last_owner, w_winner;
   logic            w_grant, w_take, w_deliver, w_stray, r_proto_err;
   logic [AW-1:0]   r_addr;
   logic            r_wen;
   logic [DW-1:0]   r_wdata;
   logic [DW/8-1:0] r_wmask;

   ysyx_23060171_arb_pick #(.LSU_FIRST(LSU_FIRST)) u_pick (
      .i_ifu_v      (i_ifu_req_valid),
      .i_lsu_v      (i_lsu_req_valid),
      .i_last_owner (r_last_owner),
      .o_grant      (w_grant),
      .o_winner     (w_winner)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_owner      <= OWN_IFU;
         r_last_owner <= OWN_LSU;
         r_proto_err  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_take) begin
            r_owner      <= w_winner;
            r_last_owner <= w_winner;
         end
         if (w_stray) r_proto_err <= 1'b1;
      end
   end

   // A response in ISSUE together with mem_req_ready is a zero-latency memory and is delivered;
   // any other response outside WAIT is stray.
   always_comb begin
      w_next          = r_state;
      w_take          = 1'b0;
      w_deliver       = 1'b0;
      w_stray         = 1'b0;
      o_mem_req_valid = 1'b0;
      case (r_state)
         IDLE: begin
            w_take  = w_grant & ~rst;
            w_stray = i_mem_resp_valid;
            if (w_take) w_next = ISSUE;
         end
         ISSUE: begin
            o_mem_req_valid = 1'b1;
            w_deliver       = i_mem_req_ready & i_mem_resp_valid;
            w_stray         = ~i_mem_req_ready & i_mem_resp_valid;
            if (i_mem_req_ready) w_next = i_mem_resp_valid ? IDLE : WAIT;
         end
         WAIT: begin
            w_deliver = i_mem_resp_valid;
            if (i_mem_resp_valid) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr  <= '0;
         r_wen   <= 1'b0;
         r_wdata <= '0;
         r_wmask <= '0;
      end else if (w_take) begin
         r_addr  <= (w_winner == OWN_LSU) ? i_lsu_addr : i_ifu_addr;
         r_wen   <= (w_winner == OWN_LSU) & i_lsu_wen;
         r_wdata <= (w_winner == OWN_LSU) ? i_lsu_wdata : '0;
         r_wmask <= (w_winner == OWN_LSU) ? i_lsu_wmask : '0;
      end
   end

   assign o_ifu_req_ready  = w_take & (w_winner == OWN_IFU);
   assign o_lsu_req_ready  = w_take & (w_winner == OWN_LSU);
   assign o_ifu_resp_valid = w_deliver & (r_owner == OWN_IFU);
   assign o_lsu_resp_valid = w_deliver & (r_owner == OWN_LSU);
   assign o_ifu_rdata      = o_ifu_resp_valid ? i_mem_rdata : '0;
   assign o_lsu_rdata      = o_lsu_resp_valid ? i_mem_rdata : '0;
   assign o_mem_addr       = r_addr;
   assign o_mem_wen        = r_wen;
   assign o_mem_wdata      = r_wdata;
   assign o_mem_wmask      = r_wmask;
   assign o_busy           = r_state != IDLE;
   assign o_proto_err      = r_proto_err;
endmodule
